codec_intf: RTL and testbench

- Serial audio front/back end that sits directly upstream and downstream of the EQ engine.
- Generates the codec clocks (MCLK, SCLK, LRCLK).
- Deserializes left-justified 16-bit stereo ADC data into parallel lft_in/rht_in and produces the frame strobes valid/valid_rise/valid_fall that drive the EQ queues.
- Serializes the EQ's lft_out/rht_out back to the codec DAC.

---
 rtl/codec_intf.sv | 107 ++++++++++
 tb/tb_codec_intf.sv | 128 ++++++++++++
 2 files changed

// File: rtl/codec_intf.sv
// codec_intf: codec clock generator plus left-justified 16-bit stereo serial receiver/transmitter
// Ports: clk, rst (sync, active-high); SDout serial ADC data in; lft_out/rht_out EQ samples to send;
//   MCLK/SCLK/LRCLK codec clocks (cnt[1]/cnt[4]/cnt[9]); SDin serial DAC data out, MSB first;
//   RSTn registered active-low codec reset; lft_in/rht_in received samples to EQ;
//   valid/valid_rise/valid_fall frame strobes.
// Macro CODEC_RST_HOLD_EN: keeps RSTn low for two frames after reset, then suppresses strobes and
//   sample updates for one more frame.
module codec_intf #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SDout,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic              RSTn,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              valid,
  output logic              valid_rise,
  output logic              valid_fall
);
  localparam logic [CNT_W-1:0] END_R = '1;
  localparam logic [CNT_W-1:0] END_L = END_R >> 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_shft_q, rx_shft_d, lft_hold_q, lft_hold_d;
  logic [DATA_W-1:0] lft_in_q, lft_in_d, rht_in_q, rht_in_d;
  logic [DATA_W-1:0] tx_shft_q, tx_shft_d, rht_hold_q, rht_hold_d;
  logic valid_q, valid_d, valid_rise_q, valid_rise_d, valid_fall_q, valid_fall_d;
  logic rstn_q, rstn_d, end_l, end_r, en;
`ifdef CODEC_RST_HOLD_EN
  // One counter covers both the two-frame codec reset and the extra discarded frame.
  localparam logic [CNT_W+1:0] HOLD_RSTN = (CNT_W+2)'((2 << CNT_W) - 1);
  localparam logic [CNT_W+1:0] HOLD_EN   = (CNT_W+2)'((3 << CNT_W) - 1);
  logic [CNT_W+1:0] hold_q, hold_d;
  always_comb begin
    hold_d = hold_q + (CNT_W+2)'(hold_q != HOLD_EN);
    rstn_d = hold_q >= HOLD_RSTN;
    en     = hold_q == HOLD_EN;
  end
  always_ff @(posedge clk) hold_q <= rst ? '0 : hold_d;
`else
  always_comb begin
    rstn_d = 1'b1;
    en     = 1'b1;
  end
`endif
  always_comb begin
    end_l        = cnt_q == END_L;
    end_r        = cnt_q == END_R;
    cnt_d        = cnt_q + CNT_W'(1);
    rx_shft_d    = (cnt_q[4:0] == 5'h0F) ? {rx_shft_q[DATA_W-2:0], SDout} : rx_shft_q;
    lft_hold_d   = end_l ? rx_shft_q : lft_hold_q;
    lft_in_d     = (end_r && en) ? lft_hold_q : lft_in_q;
    rht_in_d     = (end_r && en) ? rx_shft_q : rht_in_q;
    valid_d      = end_r ? en : end_l ? 1'b0 : valid_q;
    valid_rise_d = end_r && en;
    // a fall is only reported when valid was actually high
    valid_fall_d = end_l && valid_q;
    // half-frame loads win over the SCLK-falling shift they coincide with
    tx_shft_d    = end_r ? lft_out : end_l ? rht_hold_q :
                   (cnt_q[4:0] == 5'h1F) ? {tx_shft_q[DATA_W-2:0], 1'b0} : tx_shft_q;
    rht_hold_d   = end_r ? rht_out : rht_hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      rx_shft_q    <= '0;
      lft_hold_q   <= '0;
      lft_in_q     <= '0;
      rht_in_q     <= '0;
      tx_shft_q    <= '0;
      rht_hold_q   <= '0;
      valid_q      <= 1'b0;
      valid_rise_q <= 1'b0;
      valid_fall_q <= 1'b0;
      rstn_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rx_shft_q    <= rx_shft_d;
      lft_hold_q   <= lft_hold_d;
      lft_in_q     <= lft_in_d;
      rht_in_q     <= rht_in_d;
      tx_shft_q    <= tx_shft_d;
      rht_hold_q   <= rht_hold_d;
      valid_q      <= valid_d;
      valid_rise_q <= valid_rise_d;
      valid_fall_q <= valid_fall_d;
      rstn_q       <= rstn_d;
    end
  end
  assign MCLK       = cnt_q[1];
  assign SCLK       = cnt_q[4];
  assign LRCLK      = cnt_q[CNT_W-1];
  assign SDin       = tx_shft_q[DATA_W-1];
  assign RSTn       = rstn_q;
  assign lft_in     = lft_in_q;
  assign rht_in     = rht_in_q;
  assign valid      = valid_q;
  assign valid_rise = valid_rise_q;
  assign valid_fall = valid_fall_q;
endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: frame-level reference model plus table vectors and reset corner cases for codec_intf
module tb_codec_intf;
  logic clk = 1'b0, rst = 1'b1, SDout = 1'b0;
  logic [15:0] lft_out = '0, rht_out = '0;
  logic MCLK, SCLK, LRCLK, SDin, RSTn, valid, valid_rise, valid_fall;
  logic [15:0] lft_in, rht_in;
  int checks = 0, errors = 0;
  int k = 0;
  logic lp = 1'b0;
  logic [15:0] rx_l = '0, rx_r = '0, tx_l = '0, tx_r = '0, el = '0, er = '0;
  typedef struct {
    logic [15:0] sd_l, sd_r, eq_l, eq_r;
    logic        loop;
    logic [15:0] exp_l, exp_r;
  } vec_t;
  vec_t tbl[5];
  codec_intf dut (
    .clk(clk), .rst(rst), .SDout(SDout), .lft_out(lft_out), .rht_out(rht_out),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin), .RSTn(RSTn),
    .lft_in(lft_in), .rht_in(rht_in),
    .valid(valid), .valid_rise(valid_rise), .valid_fall(valid_fall)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s k=%0d got %0h want %0h", nm, k, act, req);
    end
  endtask
  // bit on the serial line at frame position p: left-justified, one bit per 32-cycle SCLK period
  function automatic logic ser(input logic [15:0] l, input logic [15:0] r, input int p);
    return p < 512 ? l[15 - p/32] : r[15 - (p - 512)/32];
  endfunction
  // k counts clock edges since reset release; frame position is k mod 1024
  task automatic step();
    int p;
    logic [15:0] cl, cr;
    p = k % 1024;
    SDout = lp ? SDin : ser(rx_l, rx_r, p);
    cl = lft_out;
    cr = rht_out;
    @(posedge clk);
    #1;
    k++;
    p = k % 1024;
    if (p == 0) begin
      el = rx_l; er = rx_r; tx_l = cl; tx_r = cr;
    end
    chk("clocks", {MCLK, SCLK, LRCLK}, {p[1], p[4], p >= 512});
    chk("rstn", RSTn, 1'b1);
    chk("sdin", SDin, ser(tx_l, tx_r, p));
    chk("strobes", {valid, valid_rise, valid_fall},
        {k >= 1024 && p < 512, k >= 1024 && p == 0, k >= 1024 && p == 512});
    chk("samples", {lft_in, rht_in}, {el, er});
  endtask
  task automatic run_frame(input logic [15:0] sl, input logic [15:0] sr, input logic [15:0] ql,
                           input logic [15:0] qr, input logic loop, input bit rnd);
    lp = loop;
    rx_l = loop ? tx_l : sl;
    rx_r = loop ? tx_r : sr;
    for (int i = 0; i < 1024; i++) begin
      lft_out = rnd ? 16'($urandom) : ql;
      rht_out = rnd ? 16'($urandom) : qr;
      step();
    end
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    SDout = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_outs", {MCLK, SCLK, LRCLK, SDin, RSTn}, 5'b0);
    chk("rst_strobes", {valid, valid_rise, valid_fall}, 3'b0);
    chk("rst_samples", {lft_in, rht_in}, 32'b0);
    rst = 1'b0;
    k = 0; lp = 1'b0;
    tx_l = '0; tx_r = '0; el = '0; er = '0;
  endtask
  initial begin
    int kr, kf;
    tbl[0] = '{16'h8001, 16'h7FFE, 16'h1234, 16'hABCD, 1'b0, 16'h8001, 16'h7FFE};
    tbl[1] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 16'h0000, 16'hFFFF};
    tbl[2] = '{16'h0000, 16'h0000, 16'h5A5A, 16'hA5A5, 1'b1, 16'h00FF, 16'hFF00};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 16'hA5A5};
    tbl[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0001};
    do_reset(3);
    foreach (tbl[i]) begin
      run_frame(tbl[i].sd_l, tbl[i].sd_r, tbl[i].eq_l, tbl[i].eq_r, tbl[i].loop, 1'b0);
      chk("tbl_lft", lft_in, tbl[i].exp_l);
      chk("tbl_rht", rht_in, tbl[i].exp_r);
      chk("tbl_rise", valid_rise, 1'b1);
    end
    for (int f = 0; f < 6; f++)
      run_frame(16'($urandom), 16'($urandom), '0, '0, 1'($urandom_range(0, 1)), 1'b1);
    lp = 1'b0;
    rx_l = 16'($urandom);
    rx_r = 16'($urandom);
    while (k % 1024 != 'h150) step();
    do_reset(1);
    rx_l = 16'hC3A5;
    rx_r = 16'h0F0F;
    kr = -1;
    for (int i = 0; i < 1100 && kr < 0; i++) begin
      step();
      if (valid_rise) kr = k;
    end
    chk("first_rise", 64'(kr), 64'd1024);
    chk("restart_lft", lft_in, 16'hC3A5);
    chk("restart_rht", rht_in, 16'h0F0F);
    kf = -1;
    for (int i = 0; i < 600 && kf < 0; i++) begin
      step();
      if (valid_fall) kf = k;
    end
    chk("fall_gap", 64'(kf - kr), 64'd512);
    while (k % 1024 != 0) step();
    for (int f = 0; f < 2; f++)
      run_frame(16'($urandom), 16'($urandom), '0, '0, 1'($urandom_range(0, 1)), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
